// File: rtl/sort_pkg.sv
// Shared definitions for the block sorter: element width, controller states
// and the saturating swap counter helper.
package sort_pkg;

    localparam int ELEM_W = 4;
    localparam int CNT_W  = 8;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_SORT  = 2'd1,
        ST_DRAIN = 2'd2
    } sort_state_e;

    // Swap counter sticks at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        if (&value) begin
            return value;
        end
        return value + CNT_W'(1);
    endfunction

endpackage

// File: rtl/comparator_4bit.sv
// Unsigned magnitude comparator shared by the sort controller.
// Exactly one of the three outputs is high for any input pair.
module comparator_4bit
    import sort_pkg::*;
(
    input  logic [ELEM_W-1:0] a,
    input  logic [ELEM_W-1:0] b,
    output logic              a_gt_b,
    output logic              a_eq_b,
    output logic              a_lt_b
);

    always_comb begin
        a_gt_b = (a > b);
        a_eq_b = (a == b);
        a_lt_b = (a < b);
    end

endmodule

// File: rtl/sort_ctrl_4bit.sv
// Block sorter: loads DEPTH elements, bubble-sorts them in place with one
// shared comparator (one compare per cycle), then streams the result out.
module sort_ctrl_4bit
    import sort_pkg::*;
#(
    parameter int DEPTH   = 8,
    parameter bit DESCEND = 1'b0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ELEM_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ELEM_W-1:0] out_data,
    output logic              out_last,
    output logic              busy,
    output logic [CNT_W-1:0]  swap_count
);

    localparam int PTR_W = $clog2(DEPTH);
    // One extra bit so the decremented pass limit can be tested without wrapping.
    localparam int LIM_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(DEPTH - 1);
    localparam logic [LIM_W-1:0] FIRST_LIMIT = LIM_W'(DEPTH - 1);

    logic [ELEM_W-1:0] mem [DEPTH];
    sort_state_e       state;
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  idx;
    logic [PTR_W-1:0]  idx_nxt;
    logic [LIM_W-1:0]  limit;
    logic [LIM_W-1:0]  next_limit;
    logic              pass_swapped;

    logic [ELEM_W-1:0] cmp_a;
    logic [ELEM_W-1:0] cmp_b;
    logic              a_gt_b;
    logic              a_eq_b;
    logic              a_lt_b;
    logic              do_swap;
    logic              any_swap;
    logic              pass_end;
    logic              in_fire;
    logic              out_fire;

    comparator_4bit u_cmp (
        .a      (cmp_a),
        .b      (cmp_b),
        .a_gt_b (a_gt_b),
        .a_eq_b (a_eq_b),
        .a_lt_b (a_lt_b)
    );

    always_comb begin
        idx_nxt    = idx + PTR_W'(1);
        cmp_a      = mem[idx];
        cmp_b      = mem[idx_nxt];
        // Equal neighbours are never exchanged, which keeps the sort stable.
        do_swap    = (state == ST_SORT) && !a_eq_b && (DESCEND ? a_lt_b : a_gt_b);
        any_swap   = pass_swapped | do_swap;
        pass_end   = ({1'b0, idx} == (limit - LIM_W'(1)));
        next_limit = limit - LIM_W'(1);
    end

    always_comb begin
        in_ready  = (state == ST_LOAD);
        out_valid = (state == ST_DRAIN);
        busy      = (state == ST_SORT) || (state == ST_DRAIN);
        out_data  = out_valid ? mem[rd_ptr] : '0;
        out_last  = out_valid && (rd_ptr == LAST_PTR);
        in_fire   = in_valid && in_ready;
        out_fire  = out_valid && out_ready;
    end

    // Register bank is not reset; a block in flight is simply abandoned.
    always_ff @(posedge clk) begin
        if (in_fire) begin
            mem[wr_ptr] <= in_data;
        end else if (do_swap) begin
            mem[idx]     <= cmp_b;
            mem[idx_nxt] <= cmp_a;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_LOAD;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            idx          <= '0;
            limit        <= FIRST_LIMIT;
            pass_swapped <= 1'b0;
            swap_count   <= '0;
        end else begin
            case (state)
                ST_LOAD: begin
                    if (in_fire) begin
                        wr_ptr <= wr_ptr + PTR_W'(1);
                        if (wr_ptr == LAST_PTR) begin
                            state        <= ST_SORT;
                            wr_ptr       <= '0;
                            idx          <= '0;
                            limit        <= FIRST_LIMIT;
                            pass_swapped <= 1'b0;
                            swap_count   <= '0;
                        end
                    end
                end
                ST_SORT: begin
                    if (do_swap) begin
                        swap_count <= sat_inc(swap_count);
                    end
                    if (pass_end) begin
                        // A clean pass means the bank is already ordered.
                        if (!any_swap || (next_limit == '0)) begin
                            state <= ST_DRAIN;
                        end else begin
                            idx          <= '0;
                            limit        <= next_limit;
                            pass_swapped <= 1'b0;
                        end
                    end else begin
                        idx          <= idx_nxt;
                        pass_swapped <= any_swap;
                    end
                end
                ST_DRAIN: begin
                    if (out_fire) begin
                        if (rd_ptr == LAST_PTR) begin
                            state  <= ST_LOAD;
                            rd_ptr <= '0;
                            wr_ptr <= '0;
                        end else begin
                            rd_ptr <= rd_ptr + PTR_W'(1);
                        end
                    end
                end
                default: begin
                    state <= ST_LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort_ctrl_4bit.sv
// Bench for sort_ctrl_4bit: ascending and descending instances driven with
// directed and random blocks, outputs checked against a queue-based scoreboard.
module tb_sort_ctrl_4bit;

    localparam int DEPTH = 8;

    typedef logic [3:0] blk_t [DEPTH];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid   [2];
    logic       in_ready   [2];
    logic [3:0] in_data    [2];
    logic       out_valid  [2];
    logic       out_ready  [2];
    logic [3:0] out_data   [2];
    logic       out_last   [2];
    logic       busy       [2];
    logic [7:0] swap_count [2];

    logic [4:0] exp_q0 [$];
    logic [4:0] exp_q1 [$];

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    sort_ctrl_4bit #(.DEPTH(DEPTH), .DESCEND(1'b0)) dut_asc (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid[0]),
        .in_ready   (in_ready[0]),
        .in_data    (in_data[0]),
        .out_valid  (out_valid[0]),
        .out_ready  (out_ready[0]),
        .out_data   (out_data[0]),
        .out_last   (out_last[0]),
        .busy       (busy[0]),
        .swap_count (swap_count[0])
    );

    sort_ctrl_4bit #(.DEPTH(DEPTH), .DESCEND(1'b1)) dut_desc (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid[1]),
        .in_ready   (in_ready[1]),
        .in_data    (in_data[1]),
        .out_valid  (out_valid[1]),
        .out_ready  (out_ready[1]),
        .out_data   (out_data[1]),
        .out_last   (out_last[1]),
        .busy       (busy[1]),
        .swap_count (swap_count[1])
    );

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic report_fail(input string name, input string detail);
        n_checks++;
        n_fails++;
        $display("[TB] FAIL %s: %s", name, detail);
    endtask

    function automatic int q_size(input int k);
        return (k == 0) ? exp_q0.size() : exp_q1.size();
    endfunction

    function automatic void push_exp(input int k, input logic [4:0] e);
        if (k == 0) exp_q0.push_back(e);
        else        exp_q1.push_back(e);
    endfunction

    // Reference: output is a counting sort; swaps equal the inversion count;
    // passes follow from the largest distance any element must travel left.
    function automatic void ref_model(input blk_t v, input bit desc, output blk_t srt,
                                      output int swaps, output int cycles);
        int hist [16];
        int k_max;
        int left;
        int passes;
        int pos;
        int val;
        swaps = 0;
        k_max = 0;
        for (int j = 0; j < DEPTH; j++) begin
            left = 0;
            for (int i = 0; i < j; i++) begin
                if (desc ? (v[i] < v[j]) : (v[i] > v[j])) left++;
            end
            swaps += left;
            if (left > k_max) k_max = left;
        end
        passes = (k_max + 1 < DEPTH - 1) ? k_max + 1 : DEPTH - 1;
        cycles = 0;
        for (int p = 0; p < passes; p++) cycles += DEPTH - 1 - p;
        for (int n = 0; n < 16; n++) hist[n] = 0;
        for (int i = 0; i < DEPTH; i++) hist[v[i]]++;
        pos = 0;
        for (int n = 0; n < 16; n++) begin
            val = desc ? 15 - n : n;
            for (int r = 0; r < hist[val]; r++) begin
                srt[pos] = 4'(val);
                pos++;
            end
        end
    endfunction

    // Scoreboard monitors: pop on every output transfer, and while stalled
    // the presented element must already equal the head of the queue.
    always @(negedge clk) begin : mon_asc
        logic [4:0] e;
        if (rst_n === 1'b1 && out_valid[0] === 1'b1) begin
            if (exp_q0.size() == 0) begin
                report_fail("asc extra output", $sformatf("data %0d", out_data[0]));
            end else if (out_ready[0] === 1'b1) begin
                e = exp_q0.pop_front();
                check_output("asc out_data", out_data[0], e[3:0]);
                check_output("asc out_last", out_last[0], e[4]);
            end else begin
                e = exp_q0[0];
                check_output("asc held out_data", out_data[0], e[3:0]);
                check_output("asc held out_last", out_last[0], e[4]);
            end
        end
    end

    always @(negedge clk) begin : mon_desc
        logic [4:0] e;
        if (rst_n === 1'b1 && out_valid[1] === 1'b1) begin
            if (exp_q1.size() == 0) begin
                report_fail("desc extra output", $sformatf("data %0d", out_data[1]));
            end else if (out_ready[1] === 1'b1) begin
                e = exp_q1.pop_front();
                check_output("desc out_data", out_data[1], e[3:0]);
                check_output("desc out_last", out_last[1], e[4]);
            end else begin
                e = exp_q1[0];
                check_output("desc held out_data", out_data[1], e[3:0]);
                check_output("desc held out_last", out_last[1], e[4]);
            end
        end
    end

    task automatic send(input int k, input logic [3:0] v);
        logic ok;
        int   guard;
        guard = 0;
        ok = 1'b0;
        in_valid[k] = 1'b1;
        in_data[k]  = v;
        while (!ok && guard < 50) begin
            @(negedge clk);
            ok = in_ready[k];
            @(posedge clk);
            #1;
            guard++;
        end
        if (!ok) report_fail("load timeout", $sformatf("inst %0d never ready", k));
        in_valid[k] = 1'b0;
    endtask

    task automatic check_reset_state(input int k);
        check_output($sformatf("reset in_ready[%0d]", k), in_ready[k], 1);
        check_output($sformatf("reset out_valid[%0d]", k), out_valid[k], 0);
        check_output($sformatf("reset out_data[%0d]", k), out_data[k], 0);
        check_output($sformatf("reset out_last[%0d]", k), out_last[k], 0);
        check_output($sformatf("reset busy[%0d]", k), busy[k], 0);
        check_output($sformatf("reset swap_count[%0d]", k), swap_count[k], 0);
    endtask

    task automatic apply_stimulus(input int k, input blk_t v, input bit glitch,
                                  input bit backpressure, input bit stall, input bit reset_mid);
        blk_t srt;
        int   swaps;
        int   cycles;
        int   cyc;
        int   guard;
        int   c;
        bit   seen;
        ref_model(v, k == 1, srt, swaps, cycles);
        for (int i = 0; i < DEPTH; i++) push_exp(k, {(i == DEPTH - 1), srt[i]});
        for (int i = 0; i < DEPTH; i++) send(k, v[i]);

        cyc = 0;
        seen = 1'b0;
        guard = 0;
        while (!seen && guard < 200) begin
            if (glitch) begin
                in_valid[k] = 1'($urandom_range(0, 1));
                in_data[k]  = 4'($urandom_range(0, 15));
            end
            if (reset_mid && cyc == 3) begin
                rst_n = 1'b0;
                #1;
                check_output("midreset out_valid", out_valid[k], 0);
                check_output("midreset busy", busy[k], 0);
                check_output("midreset swap_count", swap_count[k], 0);
                check_output("midreset in_ready", in_ready[k], 1);
                exp_q0.delete();
                exp_q1.delete();
                in_valid[k] = 1'b0;
                @(posedge clk);
                #1;
                rst_n = 1'b1;
                return;
            end
            @(negedge clk);
            if (out_valid[k] === 1'b1) begin
                seen = 1'b1;
            end else begin
                if (busy[k] === 1'b1) cyc++;
                if (glitch) check_output("in_ready during sort", in_ready[k], 0);
                @(posedge clk);
                #1;
            end
            guard++;
        end
        in_valid[k] = 1'b0;
        if (!seen) begin
            report_fail("sort timeout", $sformatf("inst %0d never drained", k));
            return;
        end
        check_output($sformatf("sort cycles[%0d]", k), cyc, cycles);
        check_output($sformatf("swap_count[%0d]", k), swap_count[k], swaps);

        c = 0;
        guard = 0;
        forever begin
            @(posedge clk);
            #1;
            if (q_size(k) == 0 || guard >= 300) break;
            if (stall && c >= 2 && c < 7) out_ready[k] = 1'b0;
            else if (backpressure)        out_ready[k] = 1'($urandom_range(0, 1));
            else                          out_ready[k] = 1'b1;
            c++;
            guard++;
        end
        out_ready[k] = 1'b1;
        if (q_size(k) != 0) begin
            report_fail("drain timeout", $sformatf("inst %0d left %0d elements", k, q_size(k)));
            return;
        end
        check_output($sformatf("idle busy[%0d]", k), busy[k], 0);
        check_output($sformatf("idle in_ready[%0d]", k), in_ready[k], 1);
        check_output($sformatf("held swap_count[%0d]", k), swap_count[k], swaps);
    endtask

    initial begin : watchdog
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : main
        blk_t blk;
        int   k;
        int   hi;
        for (int i = 0; i < 2; i++) begin
            in_valid[i]  = 1'b0;
            in_data[i]   = 4'd0;
            out_ready[i] = 1'b1;
        end
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_reset_state(0);
        check_reset_state(1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_output("post-reset in_ready", in_ready[0], 1);

        $display("[TB] case 1: mixed block ascending");
        blk = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6};
        apply_stimulus(0, blk, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] case 2: presorted block");
        blk = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7};
        apply_stimulus(0, blk, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] case 3: reversed block");
        blk = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8};
        apply_stimulus(0, blk, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] case 4: all equal with in_valid noise during sort");
        blk = '{default: 4'd10};
        apply_stimulus(0, blk, 1'b1, 1'b0, 1'b0, 1'b0);

        $display("[TB] case 5: consumer stall mid-drain");
        blk = '{4'd7, 4'd2, 4'd11, 4'd0, 4'd15, 4'd2, 4'd8, 4'd4};
        apply_stimulus(0, blk, 1'b0, 1'b0, 1'b1, 1'b0);

        $display("[TB] case 6: reset mid-sort then recover");
        blk = '{4'd15, 4'd14, 4'd13, 4'd12, 4'd11, 4'd10, 4'd9, 4'd8};
        apply_stimulus(0, blk, 1'b0, 1'b0, 1'b0, 1'b1);
        blk = '{4'd3, 4'd1, 4'd4, 4'd1, 4'd5, 4'd9, 4'd2, 4'd6};
        apply_stimulus(0, blk, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] case 7: mixed block descending");
        apply_stimulus(1, blk, 1'b0, 1'b0, 1'b0, 1'b0);

        $display("[TB] random blocks");
        for (int n = 0; n < 16; n++) begin
            k  = int'($urandom_range(0, 1));
            hi = ($urandom_range(0, 3) == 0) ? 3 : 15;
            for (int i = 0; i < DEPTH; i++) blk[i] = 4'($urandom_range(0, hi));
            apply_stimulus(k, blk, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                           1'($urandom_range(0, 1)), 1'b0);
        end

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
